// File: rtl/product_accumulator.sv
// Sums groups of ACC_LEN unsigned products into one wrapped result with a carry flag,
// presented on a single-entry valid/ready output register.
module product_accumulator #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACC_LEN    = 9,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_ovf,
    input  logic                  out_ready
);

    typedef enum logic {EMPTY, PENDING} out_state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(ACC_LEN - 1);

    out_state_t            state, state_next;
    logic [DATA_WIDTH-1:0] acc;
    logic                  ovf_acc;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_eff;
    logic                  is_first;
    logic                  is_final;
    logic                  accept;
    logic [DATA_WIDTH:0]   sum;
    logic                  ovf_new;

    // clr takes effect on this cycle's beat, so the beat position is evaluated as if cnt were 0
    assign cnt_eff   = clr ? '0 : cnt;
    assign is_first  = (cnt_eff == '0);
    assign is_final  = (cnt_eff == LAST);
    assign out_valid = (state == PENDING);
    assign in_ready  = !(is_final && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign sum       = is_first ? {1'b0, in_data} : ({1'b0, acc} + {1'b0, in_data});
    assign ovf_new   = is_first ? 1'b0 : (ovf_acc | sum[DATA_WIDTH]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc      <= '0;
            ovf_acc  <= 1'b0;
            cnt      <= '0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else begin
            if (accept) begin
                acc     <= sum[DATA_WIDTH-1:0];
                ovf_acc <= ovf_new;
                cnt     <= is_final ? '0 : cnt_eff + CNT_WIDTH'(1);
                if (is_final) begin
                    out_data <= sum[DATA_WIDTH-1:0];
                    out_ovf  <= ovf_new;
                end
            end else if (clr) begin
                ovf_acc <= 1'b0;
                cnt     <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (accept && is_final) state_next = PENDING;
            end
            PENDING: begin
                // a final beat arriving with out_ready reloads the register in place
                if (accept && is_final) state_next = PENDING;
                else if (out_ready)     state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 9-beat build and a single-beat build.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clr, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_ovf;
    logic [31:0] out_data;

    logic        in_valid1, out_ready1;
    logic [31:0] in_data1;
    logic        in_ready1, out_valid1, out_ovf1;
    logic [31:0] out_data1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    product_accumulator #(.DATA_WIDTH(32), .ACC_LEN(9), .CNT_WIDTH(8)) dut (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ovf(out_ovf),
        .out_ready(out_ready)
    );

    product_accumulator #(.DATA_WIDTH(32), .ACC_LEN(1), .CNT_WIDTH(8)) dut1 (
        .clk(clk), .rstn(rstn), .clr(1'b0),
        .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ovf(out_ovf1),
        .out_ready(out_ready1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one beat, confirm it is accepted, and advance past the edge
    task automatic beat(input logic [31:0] d, input string tag);
        in_valid = 1'b1;
        in_data  = d;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] d, input logic o);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_data"}, out_data, d);
        check({tag, "_ovf"}, 32'(out_ovf), 32'(o));
    endtask

    initial begin
        rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
        #1;
        check_out("rst", 1'b0, 32'd0, 1'b0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst1_valid", 32'(out_valid1), 32'd0);
        check("rst1_data", out_data1, 32'd0);
        check("rst1_in_ready", 32'(in_ready1), 32'd1);
        tick(); tick();
        rstn = 1'b1;
        tick();

        // group 1..9 back-to-back
        for (int i = 1; i <= 9; i++) begin
            beat(32'(i), "g45");
            if (i == 8) check("g45_early_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        check_out("g45", 1'b1, 32'd45, 1'b0);
        tick();
        check("g45_drained", 32'(out_valid), 32'd0);

        // carry-out flag, then flag cleared on the next group
        beat(32'hFFFF_FFFF, "ovf");
        beat(32'd2, "ovf");
        for (int i = 0; i < 7; i++) beat(32'd0, "ovf");
        check_out("ovf", 1'b1, 32'h0000_0001, 1'b1);
        for (int i = 0; i < 9; i++) beat(32'd1, "nines");
        in_valid = 1'b0;
        check_out("nines", 1'b1, 32'd9, 1'b0);
        tick();
        check("nines_drained", 32'(out_valid), 32'd0);

        // backpressure: group 1 held, group 2 stalls only on its final beat
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) beat(32'd10, "bp1");
        check_out("bp1", 1'b1, 32'd90, 1'b0);
        for (int i = 0; i < 8; i++) beat(32'd3, "bp2");
        in_valid = 1'b1;
        in_data  = 32'd3;
        #1;
        check("bp_stall_ready", 32'(in_ready), 32'd0);
        check_out("bp_hold", 1'b1, 32'd90, 1'b0);
        tick();
        check("bp_stall_ready2", 32'(in_ready), 32'd0);
        check_out("bp_hold2", 1'b1, 32'd90, 1'b0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_out("bp2", 1'b1, 32'd27, 1'b0);
        tick();
        check("bp2_drained", 32'(out_valid), 32'd0);

        // clr with a beat restarts the group from that beat
        for (int i = 0; i < 4; i++) beat(32'd100, "clr_pre");
        clr = 1'b1;
        beat(32'd5, "clr_beat");
        clr = 1'b0;
        for (int i = 0; i < 7; i++) beat(32'd1, "clr_post");
        check("clr_early_valid", 32'(out_valid), 32'd0);
        beat(32'd1, "clr_post");
        in_valid = 1'b0;
        check_out("clr", 1'b1, 32'd13, 1'b0);
        tick();

        // asynchronous reset mid-group while a result is pending
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) beat(32'd4, "pre_rst");
        for (int i = 0; i < 5; i++) beat(32'd4, "part_rst");
        in_valid = 1'b0;
        check_out("pre_rst_out", 1'b1, 32'd36, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check_out("mid_rst", 1'b0, 32'd0, 1'b0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rstn = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) beat(32'd2, "post_rst");
        in_valid = 1'b0;
        check_out("post_rst", 1'b1, 32'd18, 1'b0);
        tick();

        // single-beat groups
        in_valid1 = 1'b1;
        in_data1  = 32'd3;
        tick();
        check("len1_a_valid", 32'(out_valid1), 32'd1);
        check("len1_a_data", out_data1, 32'd3);
        check("len1_a_ovf", 32'(out_ovf1), 32'd0);
        in_data1 = 32'd7;
        tick();
        check("len1_b_valid", 32'(out_valid1), 32'd1);
        check("len1_b_data", out_data1, 32'd7);
        check("len1_b_ovf", 32'(out_ovf1), 32'd0);
        in_data1 = 32'hFFFF_FFFF;
        tick();
        check("len1_c_valid", 32'(out_valid1), 32'd1);
        check("len1_c_data", out_data1, 32'hFFFF_FFFF);
        check("len1_c_ovf", 32'(out_ovf1), 32'd0);
        in_valid1 = 1'b0;
        tick();
        check("len1_drained", 32'(out_valid1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
